// File: rtl/pet_need_engine_if.sv
// +--------------------------------------------------------------------+
// | pet_need_engine_if : action/level bundle between decoder and pet    |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

interface pet_need_engine_if #(
  parameter int NUM_NEEDS = 3,
  parameter int LEVEL_W   = 3
);
  logic                           accel;
  logic [NUM_NEEDS-1:0]           act;
  logic [NUM_NEEDS*LEVEL_W-1:0]   level;
  logic [NUM_NEEDS-1:0]           alarm;
  logic [1:0]                     mood;
  logic                           tick;

  modport master (
    output accel, act,
    input  level, alarm, mood, tick
  );

  modport slave (
    input  accel, act,
    output level, alarm, mood, tick
  );
endinterface

`default_nettype wire

// File: rtl/pet_need_engine.sv
// +--------------------------------------------------------------------+
// | pet_need_engine : saturating need levels with per-need decay timers |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module pet_need_engine #(
  parameter int NUM_NEEDS   = 3,
  parameter int LEVEL_W     = 3,
  parameter int MAX_LEVEL   = 7,
  parameter int RESET_LEVEL = 4,
  parameter int TICK_DIV    = 50_000_000,
  parameter int TEST_DIV    = 4,
  parameter int DECAY_TICKS = 5,
  parameter int LOW_THRESH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  pet_need_engine_if.slave  bus
);

  localparam int MAX_DIV = (TICK_DIV > TEST_DIV) ? TICK_DIV : TEST_DIV;
  localparam int CNT_W   = $clog2(MAX_DIV) + 1;
  localparam int DCNT_W  = $clog2(DECAY_TICKS) + 1;

  localparam logic [1:0] MOOD_CRITICAL = 2'd0;
  localparam logic [1:0] MOOD_SAD      = 2'd1;
  localparam logic [1:0] MOOD_CONTENT  = 2'd2;
  localparam logic [1:0] MOOD_HAPPY    = 2'd3;

  logic [CNT_W-1:0]     cnt_q, cnt_d, limit_m1;
  logic                 tick_q, tick_hit;
  logic [NUM_NEEDS-1:0] act_q, act_rise;
  logic [LEVEL_W-1:0]   level_q [NUM_NEEDS];
  logic [LEVEL_W-1:0]   level_d [NUM_NEEDS];
  logic [DCNT_W-1:0]    dcnt_q  [NUM_NEEDS];
  logic [DCNT_W-1:0]    dcnt_d  [NUM_NEEDS];

  // >= compare keeps a mid-count switch to the shorter period from overrunning
  assign limit_m1 = bus.accel ? CNT_W'(TEST_DIV - 1) : CNT_W'(TICK_DIV - 1);
  assign tick_hit = (cnt_q >= limit_m1);
  assign cnt_d    = tick_hit ? '0 : cnt_q + CNT_W'(1);
  assign act_rise = bus.act & ~act_q;

  always_comb begin
    for (int i = 0; i < NUM_NEEDS; i++) begin
      level_d[i] = level_q[i];
      dcnt_d[i]  = dcnt_q[i];
      if (act_rise[i]) begin
        if (level_q[i] < LEVEL_W'(MAX_LEVEL)) level_d[i] = level_q[i] + LEVEL_W'(1);
        dcnt_d[i] = '0;
      end else if (tick_hit) begin
        if (dcnt_q[i] == DCNT_W'(DECAY_TICKS - 1)) begin
          if (level_q[i] != '0) level_d[i] = level_q[i] - LEVEL_W'(1);
          dcnt_d[i] = '0;
        end else begin
          dcnt_d[i] = dcnt_q[i] + DCNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      act_q  <= '0;
      for (int i = 0; i < NUM_NEEDS; i++) begin
        level_q[i] <= LEVEL_W'(RESET_LEVEL);
        dcnt_q[i]  <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_hit;
      act_q  <= bus.act;
      for (int i = 0; i < NUM_NEEDS; i++) begin
        level_q[i] <= level_d[i];
        dcnt_q[i]  <= dcnt_d[i];
      end
    end
  end

  logic [NUM_NEEDS*LEVEL_W-1:0] level_pk;
  logic [NUM_NEEDS-1:0]         alarm_v;
  logic                         any_low, all_max;
  logic [1:0]                   mood_v;

  always_comb begin
    level_pk = '0;
    alarm_v  = '0;
    any_low  = 1'b0;
    all_max  = 1'b1;
    for (int i = 0; i < NUM_NEEDS; i++) begin
      level_pk[i*LEVEL_W +: LEVEL_W] = level_q[i];
      alarm_v[i] = (level_q[i] == '0);
      if (level_q[i] <= LEVEL_W'(LOW_THRESH)) any_low = 1'b1;
      if (level_q[i] != LEVEL_W'(MAX_LEVEL))  all_max = 1'b0;
    end
    if (|alarm_v)     mood_v = MOOD_CRITICAL;
    else if (any_low) mood_v = MOOD_SAD;
    else if (all_max) mood_v = MOOD_HAPPY;
    else              mood_v = MOOD_CONTENT;
  end

  assign bus.level = level_pk;
  assign bus.alarm = alarm_v;
  assign bus.mood  = mood_v;
  assign bus.tick  = tick_q;

endmodule

`default_nettype wire
